// File: rtl/cdc_handshake_rx.sv
// -----------------------------------------------------------------------------
// cdc_handshake_rx
//   Destination-side controller for a 4-phase req/ack clock-domain-crossing
//   bus transfer. REQ_SYNC arrives already synchronized into this clock domain.
//   Once per request the module captures the source-held bus. It presents the
//   captured word downstream with a valid/ready handshake. It then drives ACK
//   back toward the source domain.
//
// Parameters
//   BUS_WIDTH  width of the transferred data bus
//   TIMEOUT    maximum number of cycles ACK waits for req to fall (0 = never)
//   CNT_WIDTH  timeout counter width; 2**CNT_WIDTH must exceed TIMEOUT
//
// Ports
//   CLK          destination clock, the only clock in this module
//   RST          synchronous reset, active-low
//   REQ_SYNC     synchronized req level from the source domain
//   UNSYNC_BUS   source data; stable while req is high
//   RX_READY     downstream accepts SYNC_BUS
//   SYNC_BUS     captured data, registered
//   BUS_VALID    SYNC_BUS valid, held until accepted
//   ACK          ack level sent to the source domain
//   TIMEOUT_ERR  one-cycle pulse when the ack timeout expires
//   BUSY         high whenever the controller is not idle
// -----------------------------------------------------------------------------
module cdc_handshake_rx #(
  parameter int BUS_WIDTH = 8,
  parameter int TIMEOUT   = 255,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ_SYNC,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 RX_READY,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 BUS_VALID,
  output logic                 ACK,
  output logic                 TIMEOUT_ERR,
  output logic                 BUSY
);

  typedef enum logic [1:0] {
    ST_WAIT_LOW = 2'd0,
    ST_IDLE     = 2'd1,
    ST_HOLD     = 2'd2,
    ST_ACK      = 2'd3
  } state_t;

  // Counter value at which the ack phase has lasted TIMEOUT cycles. The
  // counter is cleared when ACK rises and increments once per edge.
  localparam int unsigned         TO_LAST_INT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_WIDTH-1:0] TO_LAST    = TO_LAST_INT[CNT_WIDTH-1:0];
  localparam bit                   TO_EN      = (TIMEOUT != 0);

  state_t                 state_reg;
  logic [CNT_WIDTH-1:0]   cnt_reg;
  logic [BUS_WIDTH-1:0]   sync_bus_reg;
  logic                   bus_valid_reg;
  logic                   ack_reg;
  logic                   timeout_err_reg;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      // Reset always restarts in WAIT_LOW. A req that is still high
      // (or was held through reset) therefore cannot be captured a second time.
      state_reg       <= ST_WAIT_LOW;
      cnt_reg         <= '0;
      sync_bus_reg    <= '0;
      bus_valid_reg   <= 1'b0;
      ack_reg         <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      timeout_err_reg <= 1'b0;
      case (state_reg)
        ST_WAIT_LOW: begin
          ack_reg <= 1'b0;
          if (!REQ_SYNC) begin
            state_reg <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          if (REQ_SYNC) begin
            sync_bus_reg  <= UNSYNC_BUS;
            bus_valid_reg <= 1'b1;
            state_reg     <= ST_HOLD;
          end
        end

        // The captured word is frozen here. A req that falls early is ignored
        // until the word has been delivered.
        ST_HOLD: begin
          if (RX_READY) begin
            bus_valid_reg <= 1'b0;
            ack_reg       <= 1'b1;
            cnt_reg       <= '0;
            state_reg     <= ST_ACK;
          end
        end

        ST_ACK: begin
          if (!REQ_SYNC) begin
            ack_reg   <= 1'b0;
            state_reg <= ST_IDLE;
          end else if (TO_EN && (cnt_reg == TO_LAST)) begin
            ack_reg         <= 1'b0;
            timeout_err_reg <= 1'b1;
            state_reg       <= ST_WAIT_LOW;
          end else if (cnt_reg != '1) begin
            // Saturate rather than wrap. This matters when the timeout is disabled.
            cnt_reg <= cnt_reg + CNT_WIDTH'(1);
          end
        end

        default: begin
          state_reg <= ST_WAIT_LOW;
        end
      endcase
    end
  end

  assign SYNC_BUS    = sync_bus_reg;
  assign BUS_VALID   = bus_valid_reg;
  assign ACK         = ack_reg;
  assign TIMEOUT_ERR = timeout_err_reg;
  assign BUSY        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// -----------------------------------------------------------------------------
// tb_cdc_handshake_rx
//   Directed bench for cdc_handshake_rx, built with TIMEOUT=4. A transaction-
//   level model tracks three conditions:
//     - whether a req rise may be captured,
//     - whether a word is waiting for acceptance,
//     - how long ACK has been high.
//   Every cycle the bench compares the model against the DUT outputs.
//   Literal expectations pin the directed scenarios. The bench also logs and
//   compares the accepted words against the expected sequence.
// -----------------------------------------------------------------------------
module tb_cdc_handshake_rx;

  localparam int BW = 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic [BW-1:0] bus = '0;
  logic          ready = 1'b0;
  logic [BW-1:0] sync_bus;
  logic          bus_valid;
  logic          ack;
  logic          timeout_err;
  logic          busy;

  int checks = 0;
  int failures = 0;

  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] acc_q[$];

  always #5 clk = ~clk;

  cdc_handshake_rx #(
    .BUS_WIDTH(BW),
    .TIMEOUT  (TO),
    .CNT_WIDTH(8)
  ) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .REQ_SYNC   (req),
    .UNSYNC_BUS (bus),
    .RX_READY   (ready),
    .SYNC_BUS   (sync_bus),
    .BUS_VALID  (bus_valid),
    .ACK        (ack),
    .TIMEOUT_ERR(timeout_err),
    .BUSY       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            m_started = 0;
  bit            m_armed = 0;    // req has been seen low, so a rise may capture
  bit            m_pending = 0;  // a word is waiting for downstream
  bit            m_acking = 0;   // ACK is high toward the source
  bit            m_err = 0;
  int            m_age = 0;      // cycles ACK has been high
  logic [BW-1:0] m_data = '0;

  always @(posedge clk) begin
    m_started = 1;
    if (!rst_n) begin
      m_armed   = 0;
      m_pending = 0;
      m_acking  = 0;
      m_err     = 0;
      m_age     = 0;
      m_data    = '0;
    end else begin
      m_err = 0;
      if (m_acking) begin
        m_age++;
        if (!req) begin
          m_acking = 0;
          m_armed  = 1;
        end else if (TO != 0 && m_age >= TO) begin
          m_acking = 0;
          m_err    = 1;
        end
      end else if (m_pending) begin
        if (ready) begin
          m_pending = 0;
          m_acking  = 1;
          m_age     = 0;
        end
      end else if (!m_armed) begin
        if (!req) m_armed = 1;
      end else if (req) begin
        m_data    = bus;
        m_pending = 1;
        m_armed   = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("model_sync_bus", sync_bus, m_data);
      chk("model_bus_valid", bus_valid, m_pending);
      chk("model_ack", ack, m_acking);
      chk("model_timeout_err", timeout_err, m_err);
      chk("model_busy", busy, !(m_armed && !m_pending && !m_acking));
    end
  end

  // Acceptance log. Valid&ready seen here completes on the next edge.
  always @(negedge clk) begin
    if (rst_n && bus_valid && ready) begin
      acc_q.push_back(sync_bus);
      $display("accept #%0d data=0x%02h t=%0t", acc_q.size(), sync_bus, $time);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [BW-1:0] d);
    int n;
    bus = d; req = 1'b1; ready = 1'b1;
    exp_q.push_back(d);
    n = 0;
    while (!ack && n < 20) begin step(); n++; end
    chk("xfer_ack_rise", ack, 1);
    req = 1'b0;
    n = 0;
    while (ack && n < 20) begin step(); n++; end
    chk("xfer_ack_fall", ack, 0);
    ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_cycles;
    int acc_before;

    // 1. reset
    rst_n = 1'b0; req = 1'b0; ready = 1'b0; bus = '0;
    step(); step();
    chk("t1_sync_bus", sync_bus, 0);
    chk("t1_valid", bus_valid, 0);
    chk("t1_ack", ack, 0);
    chk("t1_err", timeout_err, 0);
    chk("t1_busy_wait_low", busy, 1);
    rst_n = 1'b1;
    step();
    chk("t1_busy_idle", busy, 0);

    // 2. immediate acceptance
    bus = 8'hA5; req = 1'b1; ready = 1'b1; exp_q.push_back(8'hA5);
    step();
    chk("t2_valid", bus_valid, 1);
    chk("t2_sync_bus", sync_bus, 8'hA5);
    chk("t2_ack_low", ack, 0);
    step();
    chk("t2_valid_drop", bus_valid, 0);
    chk("t2_ack_high", ack, 1);
    req = 1'b0; ready = 1'b0;
    step();
    chk("t2_ack_fall", ack, 0);
    chk("t2_busy", busy, 0);

    // 3. backpressure; later bus changes must be ignored
    bus = 8'h3C; req = 1'b1; ready = 1'b0; exp_q.push_back(8'h3C);
    step();
    bus = 8'hFF;
    repeat (4) step();
    chk("t3_valid_held", bus_valid, 1);
    chk("t3_sync_frozen", sync_bus, 8'h3C);
    chk("t3_ack_low", ack, 0);
    ready = 1'b1;
    step();
    chk("t3_ack_high", ack, 1);
    chk("t3_valid_drop", bus_valid, 0);
    req = 1'b0; ready = 1'b0;
    step();
    chk("t3_ack_fall", ack, 0);

    // 4. ack timeout with req held high
    bus = 8'h5A; req = 1'b1; ready = 1'b1; exp_q.push_back(8'h5A);
    step();
    step();
    ready = 1'b0;
    chk("t4_ack_high", ack, 1);
    ack_cycles = 1;
    for (int i = 0; i < 10 && ack; i++) begin
      step();
      if (ack) ack_cycles++;
    end
    chk("t4_ack_cycles", ack_cycles, 4);
    chk("t4_err_pulse", timeout_err, 1);
    step();
    chk("t4_err_one_cycle", timeout_err, 0);
    repeat (3) step();
    chk("t4_no_recapture", bus_valid, 0);
    chk("t4_busy_wait_low", busy, 1);
    req = 1'b0;
    step();
    chk("t4_idle_again", busy, 0);
    bus = 8'hC3; req = 1'b1; ready = 1'b1; exp_q.push_back(8'hC3);
    step();
    chk("t4_recapture", bus_valid, 1);
    chk("t4_recapture_data", sync_bus, 8'hC3);
    step();
    chk("t4_re_ack", ack, 1);
    req = 1'b0; ready = 1'b0;
    step();

    // 5. reset during HOLD with req kept high
    bus = 8'h77; req = 1'b1; ready = 1'b0;
    step();
    chk("t5_hold", bus_valid, 1);
    rst_n = 1'b0;
    step();
    chk("t5_rst_valid", bus_valid, 0);
    chk("t5_rst_sync_bus", sync_bus, 0);
    rst_n = 1'b1;
    repeat (3) step();
    chk("t5_no_recapture", bus_valid, 0);
    chk("t5_ack_low", ack, 0);
    chk("t5_busy", busy, 1);
    req = 1'b0;
    step();
    bus = 8'h99; req = 1'b1; ready = 1'b1; exp_q.push_back(8'h99);
    step();
    chk("t5_capture", sync_bus, 8'h99);
    step();
    chk("t5_ack", ack, 1);
    req = 1'b0; ready = 1'b0;
    step();

    // 6. back-to-back transfers
    acc_before = acc_q.size();
    xfer(8'h11);
    xfer(8'h22);
    step();
    chk("t6_accept_count", acc_q.size() - acc_before, 2);

    // accepted-word sequence over the whole run
    chk("acc_total", acc_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      chk("acc_data", acc_q[i], exp_q[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
